control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 121 ++++++++++++
 tb/tb_control_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: decodes a 3-bit opcode into 1-3 EXEC micro-steps
// driving register control codes and ALU select. Optional SEQ_INSTR_COUNT_EN adds instr_count.
module control_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  output logic [2:0]       Tx,
  output logic [2:0]       Ty,
  output logic [2:0]       Tz,
  output logic [1:0]       ula_sel,
  output logic             busy,
`ifdef SEQ_INSTR_COUNT_EN
  output logic             done,
  output logic [CNT_W-1:0] instr_count
`else
  output logic             done
`endif
);

  localparam logic [2:0] HOLD   = 3'b000;
  localparam logic [2:0] LOAD   = 3'b001;
  localparam logic [2:0] SHIFTR = 3'b010;
  localparam logic [2:0] SHIFTL = 3'b011;
  localparam logic [2:0] RESET  = 3'b100;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LDX = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    EXEC2 = 3'd2,
    EXEC3 = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [1:0] steps;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_CLR;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) op_q <= opcode;
    end
  end

  // Number of EXEC micro-steps for the latched opcode
  always_comb begin
    steps = 2'd1;
    if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_AND) steps = 2'd2;
    else if (op_q == OP_MOV)                                 steps = 2'd3;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? EXEC1 : IDLE;
      EXEC1:   state_d = (steps == 2'd1) ? DONE : EXEC2;
      EXEC2:   state_d = (steps == 2'd2) ? DONE : EXEC3;
      EXEC3:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode: outputs depend only on state_q and op_q
  always_comb begin
    Tx      = HOLD;
    Ty      = HOLD;
    Tz      = HOLD;
    ula_sel = 2'b00;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      EXEC1: begin
        busy = 1'b1;
        case (op_q)
          OP_CLR: begin Tx = RESET; Ty = RESET; Tz = RESET; end
          OP_LDX: Tx = LOAD;
          OP_ADD: begin ula_sel = 2'b00; Ty = LOAD; end
          OP_SUB: begin ula_sel = 2'b01; Ty = LOAD; end
          OP_AND: begin ula_sel = 2'b10; Ty = LOAD; end
          OP_SHR: Tz = SHIFTR;
          OP_SHL: Tz = SHIFTL;
          default: begin ula_sel = 2'b11; Ty = LOAD; end
        endcase
      end
      EXEC2: begin
        busy = 1'b1;
        if (steps != 2'd1) Tz = LOAD;
      end
      EXEC3: begin
        busy = 1'b1;
        if (op_q == OP_MOV) Tx = RESET;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_INSTR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                        instr_count <= '0;
    else if (state_q == DONE && instr_count != '1)  instr_count <= instr_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random stimulus checked
// cycle-by-cycle against a queue-based model of the opcode micro-step table.
module tb_control_sequencer;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam logic [12:0] IDLE_V = 13'd0;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] opcode;
  logic [2:0] Tx, Ty, Tz;
  logic [1:0] ula_sel;
  logic       busy, done;
`ifdef SEQ_INSTR_COUNT_EN
  logic [TB_CNT_W-1:0] instr_count;
`endif

  int total = 0;
  int bad   = 0;

`ifdef SEQ_INSTR_COUNT_EN
  control_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .Tx(Tx), .Ty(Ty), .Tz(Tz), .ula_sel(ula_sel),
    .busy(busy), .done(done), .instr_count(instr_count));
`else
  control_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .Tx(Tx), .Ty(Ty), .Tz(Tz), .ula_sel(ula_sel),
    .busy(busy), .done(done));
`endif

  always #5 clk = ~clk;

  // Model state: record = {Tx,Ty,Tz,ula_sel,busy,done}
  logic [12:0] m_q[$];
  logic [12:0] exp_v;
  logic [2:0]  m_opq;
  int          m_cnt;
  bit          m_prev_done;

  function automatic logic [12:0] obs();
    return {Tx, Ty, Tz, ula_sel, busy, done};
  endfunction

  function automatic void push_step(logic [2:0] x, logic [2:0] y, logic [2:0] z, logic [1:0] u);
    m_q.push_back({x, y, z, u, 1'b1, 1'b0});
  endfunction

  // Instruction table: per-opcode list of micro-steps, followed by the done cycle
  function automatic void load_program(logic [2:0] op);
    case (op)
      3'd0: push_step(3'd4, 3'd4, 3'd4, 2'd0);
      3'd1: push_step(3'd1, 3'd0, 3'd0, 2'd0);
      3'd2: begin push_step(3'd0, 3'd1, 3'd0, 2'd0); push_step(3'd0, 3'd0, 3'd1, 2'd0); end
      3'd3: begin push_step(3'd0, 3'd1, 3'd0, 2'd1); push_step(3'd0, 3'd0, 3'd1, 2'd0); end
      3'd4: begin push_step(3'd0, 3'd1, 3'd0, 2'd2); push_step(3'd0, 3'd0, 3'd1, 2'd0); end
      3'd5: push_step(3'd0, 3'd0, 3'd2, 2'd0);
      3'd6: push_step(3'd0, 3'd0, 3'd3, 2'd0);
      default: begin
        push_step(3'd0, 3'd1, 3'd0, 2'd3);
        push_step(3'd0, 3'd0, 3'd1, 2'd0);
        push_step(3'd4, 3'd0, 3'd0, 2'd0);
      end
    endcase
    m_q.push_back(13'b1);
  endfunction

  // Drive one cycle's inputs, advance an edge, update the model, sample #1 later
  task automatic cycle(input logic s, input logic [2:0] op, input logic r);
    @(negedge clk);
    start = s; opcode = op; rst = r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_opq = 3'd0;
      m_cnt = 0;
      exp_v = IDLE_V;
    end else begin
      if (m_prev_done && m_cnt != CNT_MAX) m_cnt++;
      if (m_q.size() == 0 && !m_prev_done && s) begin
        load_program(op);
        m_opq = op;
      end
      exp_v = (m_q.size() != 0) ? m_q.pop_front() : IDLE_V;
    end
    m_prev_done = exp_v[0];
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 3'd7, 1'b1);
    cycle(1'b1, 3'd7, 1'b1);
    total++;
    if (obs() !== IDLE_V) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), IDLE_V);
    end
    total++;
    if (dut.op_q !== 3'd0) begin
      bad++; $display("FAIL reset_opq got=%0d want=0", dut.op_q);
    end
    cycle(1'b0, 3'd0, 1'b0);
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", obs(), exp_v);
    end
  endtask

  task automatic test_ldx();
    cycle(1'b1, 3'd1, 1'b0);
    total++;
    if (Tx !== 3'b001 || busy !== 1'b1 || obs() !== exp_v) begin
      bad++; $display("FAIL ldx_e1 got Tx=%b busy=%b rec=%h want Tx=001 busy=1 rec=%h", Tx, busy, obs(), exp_v);
    end
    cycle(1'b0, 3'd1, 1'b0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || Tx !== 3'b000) begin
      bad++; $display("FAIL ldx_done got done=%b busy=%b Tx=%b want 1/0/000", done, busy, Tx);
    end
    cycle(1'b0, 3'd1, 1'b0);
    total++;
    if (obs() !== 13'd0 || exp_v !== IDLE_V) begin
      bad++; $display("FAIL ldx_idle got=%h want=0", obs());
    end
  endtask

  task automatic test_mov();
    cycle(1'b1, 3'd7, 1'b0);
    total++;
    if (ula_sel !== 2'b11 || Ty !== 3'b001 || Tx !== 3'b000 || Tz !== 3'b000) begin
      bad++; $display("FAIL mov_e1 got ula=%b Ty=%b Tx=%b Tz=%b want 11/001/000/000", ula_sel, Ty, Tx, Tz);
    end
    cycle(1'b0, 3'd0, 1'b0);
    total++;
    if (Tz !== 3'b001 || ula_sel !== 2'b00 || Ty !== 3'b000 || busy !== 1'b1) begin
      bad++; $display("FAIL mov_e2 got Tz=%b ula=%b Ty=%b busy=%b want 001/00/000/1", Tz, ula_sel, Ty, busy);
    end
    cycle(1'b0, 3'd0, 1'b0);
    total++;
    if (Tx !== 3'b100 || Tz !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL mov_e3 got Tx=%b Tz=%b busy=%b done=%b want 100/000/1/0", Tx, Tz, busy, done);
    end
    cycle(1'b0, 3'd0, 1'b0);
    total++;
    if (done !== 1'b1 || obs() !== exp_v) begin
      bad++; $display("FAIL mov_done got=%h want=%h", obs(), exp_v);
    end
    cycle(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    cycle(1'b1, 3'd2, 1'b0);
    cycle(1'b1, 3'd5, 1'b0);
    total++;
    if (Tz !== 3'b001 || busy !== 1'b1 || dut.op_q !== 3'd2) begin
      bad++; $display("FAIL ignore_e2 got Tz=%b busy=%b op_q=%0d want 001/1/2", Tz, busy, dut.op_q);
    end
    cycle(1'b1, 3'd5, 1'b0);
    total++;
    if (done !== 1'b1 || obs() !== exp_v) begin
      bad++; $display("FAIL ignore_done got=%h want=%h", obs(), exp_v);
    end
    cycle(1'b0, 3'd5, 1'b0);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || obs() !== exp_v) begin
      bad++; $display("FAIL ignore_noextra got=%h want=%h", obs(), exp_v);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    cycle(1'b1, 3'd3, 1'b0);
    cycle(1'b0, 3'd3, 1'b0);
    total++;
    if (Tz !== 3'b001) begin
      bad++; $display("FAIL rstmid_e2 got Tz=%b want 001", Tz);
    end
    cycle(1'b0, 3'd3, 1'b1);
    total++;
    if (Tz !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || dut.op_q !== 3'd0) begin
      bad++; $display("FAIL rstmid_idle got Tz=%b busy=%b done=%b op_q=%0d want 000/0/0/0", Tz, busy, done, dut.op_q);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 3'd3, 1'b0);
      if (done) saw_done = 1;
    end
    total++;
    if (saw_done) begin
      bad++; $display("FAIL rstmid_nodone got done pulse want none");
    end
  endtask

  task automatic test_back_to_back();
    int n_shl = 0, n_done = 0, n_err = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 3'd6, 1'b0);
      if (Tz === 3'b011) n_shl++;
      if (done === 1'b1) n_done++;
      if ((i % 3 == 0) !== (Tz === 3'b011) || (i % 3 == 1) !== (done === 1'b1)) n_err++;
    end
    total++;
    if (n_shl != 3 || n_done != 3 || n_err != 0) begin
      bad++; $display("FAIL b2b got shl=%0d done=%0d misplaced=%0d want 3/3/0", n_shl, n_done, n_err);
    end
    cycle(1'b0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 1'b0);
  endtask

`ifdef SEQ_INSTR_COUNT_EN
  task automatic test_count();
    int want[5] = '{1, 2, 3, 3, 3};
    cycle(1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 3'd1, 1'b0);
      cycle(1'b0, 3'd1, 1'b0);
      cycle(1'b0, 3'd1, 1'b0);
      total++;
      if (int'(instr_count) != want[k] || m_cnt != want[k]) begin
        bad++; $display("FAIL count_%0d got=%0d want=%0d", k, instr_count, want[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
      total++;
      if (obs() !== exp_v || dut.op_q !== m_opq) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL random_%0d got=%h op_q=%0d want=%h op_q=%0d", i, obs(), dut.op_q, exp_v, m_opq);
      end
`ifdef SEQ_INSTR_COUNT_EN
      total++;
      if (int'(instr_count) != m_cnt) begin
        bad++; $display("FAIL random_cnt_%0d got=%0d want=%0d", i, instr_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 3'd0;
    m_opq = 3'd0; m_cnt = 0; m_prev_done = 0; exp_v = IDLE_V;
    test_reset();
    test_ldx();
    test_mov();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_INSTR_COUNT_EN
    test_count();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
